sr_cmd_debouncer: RTL and testbench

SR_CMD_DEBOUNCER -- requirements
Module: sr_cmd_debouncer

---
 rtl/sr_cmd_debouncer.sv | 160 ++++++++++++++++
 tb/tb_sr_cmd_debouncer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_debouncer.sv
// Debounces two raw pushbuttons and converts their press events into one-cycle
// s/r command pulses for a downstream SR flip-flop, with post-command lockout.
module sr_cmd_debouncer #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       clr_btn,
  output logic       s,
  output logic       r,
  output logic       conflict,
  output logic       dropped,
  output logic [7:0] cmd_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam logic [8:0] DEB_TARGET = 9'(DEB_CYCLES);
  localparam logic [7:0] HOLD_LOAD  = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

  // Bit 0 carries the set button, bit 1 the clear button.
  logic [1:0] sync1_r;
  logic [1:0] sync2_r;
  logic [1:0] deb_r;
  logic [1:0] deb_d_r;
  logic [7:0] cnt_r [2];

  logic [1:0] deb_nxt_s;
  logic [7:0] cnt_nxt_s [2];
  logic [1:0] rise_s;

  logic [1:0] state_r;
  logic [7:0] hold_r;
  logic       s_r;
  logic       r_r;
  logic       conflict_r;
  logic       dropped_r;
  logic [7:0] cmd_cnt_r;

  logic [1:0] state_nxt_s;
  logic [7:0] hold_nxt_s;
  logic       s_nxt_s;
  logic       r_nxt_s;
  logic       conflict_nxt_s;
  logic       dropped_nxt_s;
  logic [7:0] cmd_cnt_nxt_s;

  // Per-button debounce counters: level toggles once the mismatch has persisted DEB_CYCLES samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_nxt_s[i] = deb_r[i];
      cnt_nxt_s[i] = 8'd0;
      if (sync2_r[i] == deb_r[i]) begin
        cnt_nxt_s[i] = 8'd0;
      end else if (({1'b0, cnt_r[i]} + 9'd1) == DEB_TARGET) begin
        cnt_nxt_s[i] = 8'd0;
        deb_nxt_s[i] = ~deb_r[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + 8'd1;
      end
    end
  end

  assign rise_s = deb_r & ~deb_d_r;

  // Command FSM and registered output pulse generation.
  always_comb begin
    state_nxt_s    = state_r;
    hold_nxt_s     = hold_r;
    s_nxt_s        = 1'b0;
    r_nxt_s        = 1'b0;
    conflict_nxt_s = 1'b0;
    dropped_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s == 2'b11) begin
          conflict_nxt_s = 1'b1;
        end else if (rise_s == 2'b01) begin
          s_nxt_s     = 1'b1;
          state_nxt_s = ST_PULSE;
        end else if (rise_s == 2'b10) begin
          r_nxt_s     = 1'b1;
          state_nxt_s = ST_PULSE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PULSE: begin
        dropped_nxt_s = |rise_s;
        if (HOLD_CYCLES > 0) begin
          state_nxt_s = ST_HOLDOFF;
          hold_nxt_s  = HOLD_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        dropped_nxt_s = |rise_s;
        if (hold_r == 8'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          hold_nxt_s = hold_r - 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        hold_nxt_s  = 8'd0;
      end
    endcase
    if (s_nxt_s || r_nxt_s) begin
      cmd_cnt_nxt_s = cmd_cnt_r + 8'd1;
    end else begin
      cmd_cnt_nxt_s = cmd_cnt_r;
    end
  end

  // All state registers; rst clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r    <= 2'b00;
      sync2_r    <= 2'b00;
      deb_r      <= 2'b00;
      deb_d_r    <= 2'b00;
      cnt_r[0]   <= 8'd0;
      cnt_r[1]   <= 8'd0;
      state_r    <= ST_IDLE;
      hold_r     <= 8'd0;
      s_r        <= 1'b0;
      r_r        <= 1'b0;
      conflict_r <= 1'b0;
      dropped_r  <= 1'b0;
      cmd_cnt_r  <= 8'd0;
    end else begin
      sync1_r    <= {clr_btn, set_btn};
      sync2_r    <= sync1_r;
      deb_r      <= deb_nxt_s;
      deb_d_r    <= deb_r;
      cnt_r[0]   <= cnt_nxt_s[0];
      cnt_r[1]   <= cnt_nxt_s[1];
      state_r    <= state_nxt_s;
      hold_r     <= hold_nxt_s;
      s_r        <= s_nxt_s;
      r_r        <= r_nxt_s;
      conflict_r <= conflict_nxt_s;
      dropped_r  <= dropped_nxt_s;
      cmd_cnt_r  <= cmd_cnt_nxt_s;
    end
  end

  assign s        = s_r;
  assign r        = r_r;
  assign conflict = conflict_r;
  assign dropped  = dropped_r;
  assign cmd_cnt  = cmd_cnt_r;

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Directed self-checking bench for sr_cmd_debouncer at default parameters.
module tb_sr_cmd_debouncer;

  logic       clk;
  logic       rst;
  logic       set_btn;
  logic       clr_btn;
  logic       s;
  logic       r;
  logic       conflict;
  logic       dropped;
  logic [7:0] cmd_cnt;

  int checks = 0;
  int errors = 0;

  sr_cmd_debouncer #(.DEB_CYCLES(4), .HOLD_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
    .s(s), .r(r), .conflict(conflict), .dropped(dropped), .cmd_cnt(cmd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; set_btn = 1'b0; clr_btn = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s, r, conflict, dropped, cmd_cnt} !== 12'd0) begin
      errors++;
      $display("FAIL reset_async: outputs=%h expected 000", {s, r, conflict, dropped, cmd_cnt});
    end
    for (int k = 0; k < 12; k++) begin
      set_btn = 1'b1;
      clr_btn = k[1];
      tick();
      checks++;
      if ({s, r, conflict, dropped, cmd_cnt} !== 12'd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: outputs=%h expected 000", k, {s, r, conflict, dropped, cmd_cnt});
      end
    end
    set_btn = 1'b0; clr_btn = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency;
    set_btn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (s !== (k == 7) || r !== 1'b0) begin
        errors++;
        $display("FAIL latency edge %0d: s=%b r=%b expected s=%b r=0", k, s, r, (k == 7));
      end
    end
    checks++;
    if (cmd_cnt !== 8'd1) begin
      errors++;
      $display("FAIL latency_cnt: cmd_cnt=%0d expected 1", cmd_cnt);
    end
    set_btn = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_bounce;
    for (int k = 0; k < 8; k++) begin
      clr_btn = (k % 2 == 0);
      tick();
      checks++;
      if (r !== 1'b0 || s !== 1'b0) begin
        errors++;
        $display("FAIL bounce cycle %0d: s=%b r=%b expected 0 0", k, s, r);
      end
    end
    clr_btn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (r !== 1'b0) begin
        errors++;
        $display("FAIL bounce_tail cycle %0d: r=%b expected 0", k, r);
      end
    end
    checks++;
    if (cmd_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bounce_cnt: cmd_cnt=%0d expected 1", cmd_cnt);
    end
  endtask

  task automatic test_conflict;
    set_btn = 1'b1; clr_btn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (conflict !== (k == 7) || s !== 1'b0 || r !== 1'b0 || dropped !== 1'b0) begin
        errors++;
        $display("FAIL conflict edge %0d: conflict=%b s=%b r=%b dropped=%b expected conflict=%b s=0 r=0 dropped=0",
                 k, conflict, s, r, dropped, (k == 7));
      end
    end
    checks++;
    if (cmd_cnt !== 8'd1) begin
      errors++;
      $display("FAIL conflict_cnt: cmd_cnt=%0d expected 1", cmd_cnt);
    end
    set_btn = 1'b0; clr_btn = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_dropped;
    set_btn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      checks++;
      if (s !== (k == 7) || dropped !== (k == 9) || r !== 1'b0) begin
        errors++;
        $display("FAIL dropped edge %0d: s=%b dropped=%b r=%b expected s=%b dropped=%b r=0",
                 k, s, dropped, r, (k == 7), (k == 9));
      end
      if (k == 2) clr_btn = 1'b1;
    end
    set_btn = 1'b0; clr_btn = 1'b0;
    repeat (12) tick();
    checks++;
    if (cmd_cnt !== 8'd2) begin
      errors++;
      $display("FAIL dropped_cnt: cmd_cnt=%0d expected 2", cmd_cnt);
    end
    clr_btn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (r !== (k == 7) || s !== 1'b0) begin
        errors++;
        $display("FAIL after_holdoff edge %0d: r=%b s=%b expected r=%b s=0", k, r, s, (k == 7));
      end
    end
    checks++;
    if (cmd_cnt !== 8'd3) begin
      errors++;
      $display("FAIL after_holdoff_cnt: cmd_cnt=%0d expected 3", cmd_cnt);
    end
    clr_btn = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_wrap;
    int pulses;
    int both;
    int pre_last;
    pulses = 0; both = 0; pre_last = -1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (cmd_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_start: cmd_cnt=%0d expected 0", cmd_cnt);
    end
    for (int n = 0; n < 256; n++) begin
      if (n == 255) pre_last = int'(cmd_cnt);
      if (n % 2 == 0) set_btn = 1'b1;
      else clr_btn = 1'b1;
      for (int k = 1; k <= 19; k++) begin
        tick();
        if (s && r) both++;
        if ((n % 2 == 0) ? s : r) pulses++;
        if (k == 9) begin
          set_btn = 1'b0; clr_btn = 1'b0;
        end
      end
    end
    checks++;
    if (pre_last !== 255) begin
      errors++;
      $display("FAIL wrap_255: cmd_cnt=%0d expected 255", pre_last);
    end
    checks++;
    if (cmd_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_end: cmd_cnt=%0d expected 0", cmd_cnt);
    end
    checks++;
    if (pulses !== 256) begin
      errors++;
      $display("FAIL wrap_pulses: pulses=%0d expected 256", pulses);
    end
    checks++;
    if (both !== 0) begin
      errors++;
      $display("FAIL wrap_exclusive: s&r cycles=%0d expected 0", both);
    end
  endtask

  task automatic test_reset_mid_pulse;
    set_btn = 1'b1;
    repeat (7) tick();
    checks++;
    if (s !== 1'b1) begin
      errors++;
      $display("FAIL midpulse_pre: s=%b expected 1", s);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (s !== 1'b0 || r !== 1'b0 || cmd_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midpulse_rst: s=%b r=%b cmd_cnt=%0d expected 0 0 0", s, r, cmd_cnt);
    end
    #1 rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (s !== (k == 7) || r !== 1'b0) begin
        errors++;
        $display("FAIL midpulse_redo edge %0d: s=%b r=%b expected s=%b r=0", k, s, r, (k == 7));
      end
    end
    checks++;
    if (cmd_cnt !== 8'd1) begin
      errors++;
      $display("FAIL midpulse_cnt: cmd_cnt=%0d expected 1", cmd_cnt);
    end
    set_btn = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_conflict();
    test_dropped();
    test_wrap();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
